stage_mem_writer: RTL

STAGE_MEM_WRITER -- requirements
Module: stage_mem_writer

---
 rtl/stage_mem_writer_pkg.sv | 25 ++
 rtl/stage_mem_writer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/stage_mem_writer_pkg.sv
// rtl/stage_mem_writer_pkg.sv - shared op, state and response-width definitions
// Purpose: lookup package imported by stage_mem_writer.
// Contents: op_e command encodings, state_e controller states, RSP_STAGE_W.
package stage_mem_writer_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_FILL  = 2'd1,
    OP_READ  = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_FILL    = 3'd2,
    S_RD_ADDR = 3'd3,
    S_RD_WAIT = 3'd4,
    S_RSP     = 3'd5
  } state_e;

  // Width of the stage tag carried in every response.
  localparam int RSP_STAGE_W = 8;

endpackage

// File: rtl/stage_mem_writer.sv
// rtl/stage_mem_writer.sv - command-driven writer/reader for one stage RAM port
// Purpose: accepts WRITE / FILL / READ commands, drives one port of a dual-port
//   RAM with 1-cycle read latency, and returns one response per command.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cmd_valid/cmd_ready           command handshake (ready only when idle)
//   cmd_op, cmd_addr, cmd_len,
//   cmd_data                      command fields, captured at acceptance
//   mem_wr, mem_addr, mem_din     RAM port controls
//   mem_dout                      RAM read data (valid one cycle after address)
//   rsp_valid/rsp_ready           response handshake
//   rsp_data, rsp_err, rsp_stage  response payload, held until accepted
//   busy                          high whenever not idle
//   wr_count                      RAM words written since reset (wraps)
import stage_mem_writer_pkg::*;

module stage_mem_writer #(
  parameter int STAGE_ID = 0,
  parameter int DATA     = 72,
  parameter int ADDR     = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [ADDR-1:0]        cmd_addr,
  input  logic [ADDR:0]          cmd_len,
  input  logic [DATA-1:0]        cmd_data,
  output logic                   mem_wr,
  output logic [ADDR-1:0]        mem_addr,
  output logic [DATA-1:0]        mem_din,
  input  logic [DATA-1:0]        mem_dout,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA-1:0]        rsp_data,
  output logic                   rsp_err,
  output logic [RSP_STAGE_W-1:0] rsp_stage,
  output logic                   busy,
  output logic [31:0]            wr_count
);

  // Largest legal FILL length is the full address space, 2**ADDR words.
  localparam logic [ADDR:0]            MAX_LEN   = {1'b1, {ADDR{1'b0}}};
  localparam logic [RSP_STAGE_W-1:0]   STAGE_TAG = RSP_STAGE_W'(STAGE_ID);

  state_e          state_q, state_d;
  logic [ADDR-1:0] addr_q, addr_d;
  logic [ADDR:0]   len_q, len_d;
  logic [DATA-1:0] data_q, data_d;
  logic [DATA-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic [31:0]     wr_count_q, wr_count_d;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_din    = '0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d     = cmd_addr;
          len_d      = cmd_len;
          data_d     = cmd_data;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          case (cmd_op)
            OP_WRITE: state_d = S_WRITE;
            OP_FILL: begin
              if (cmd_len > MAX_LEN) begin
                rsp_err_d = 1'b1;
                state_d   = S_RSP;
              end else if (cmd_len == '0) begin
                state_d = S_RSP;
              end else begin
                state_d = S_FILL;
              end
            end
            OP_READ: state_d = S_RD_ADDR;
            default: begin
              rsp_err_d = 1'b1;
              state_d   = S_RSP;
            end
          endcase
        end
      end
      S_WRITE: begin
        mem_wr   = 1'b1;
        mem_addr = addr_q;
        mem_din  = data_q;
        state_d  = S_RSP;
      end
      S_FILL: begin
        mem_wr   = 1'b1;
        mem_addr = addr_q;
        mem_din  = data_q;
        // Address wraps naturally at ADDR bits; len_q counts words remaining.
        addr_d   = addr_q + 1'b1;
        len_d    = len_q - 1'b1;
        if (len_q == {{ADDR{1'b0}}, 1'b1}) begin
          state_d = S_RSP;
        end
      end
      S_RD_ADDR: begin
        mem_addr = addr_q;
        state_d  = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        // RAM output now reflects the address presented last cycle.
        rsp_data_d = mem_dout;
        state_d    = S_RSP;
      end
      S_RSP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    wr_count_d = wr_count_q + {31'd0, mem_wr};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      data_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_RSP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_stage = STAGE_TAG;
  assign wr_count  = wr_count_q;

endmodule
